arm_pipe_hazard_ctrl: RTL and testbench

- Pipeline controller for the 5-stage ARM datapath (F/D/E/M/W).
- Carries decoded control bits from Decode through the E, M and W control registers and holds the NZCV flags register.
- Evaluates the condition field in Execute.
- Generates forwarding selects, stalls and flushes for the datapath's pipeline registers and hazard muxes.

---
 rtl/arm_pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_arm_pipe_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_pipe_hazard_ctrl.sv
// Control path for the 5-stage ARM pipeline: E/M/W control registers, NZCV flags,
// condition evaluation in Execute, and forwarding/stall/flush generation.
module arm_pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic [3:0] Match,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BranchTakenE,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic [3:0] FlagsQ
);

  logic       regwrite_e, memtoreg_e, memwrite_e, branch_e, pcsrc_e;
  logic [1:0] flagwrite_e;
  logic [3:0] cond_e;
  logic       regwrite_m, memtoreg_m, pcsrc_m;
  logic       condex_e, ldrstall, pcwr_pending;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;

  always_comb begin
    condex_e = 1'b0;
    case (cond_e)
      4'b0000: condex_e = flag_z;
      4'b0001: condex_e = ~flag_z;
      4'b0010: condex_e = flag_c;
      4'b0011: condex_e = ~flag_c;
      4'b0100: condex_e = flag_n;
      4'b0101: condex_e = ~flag_n;
      4'b0110: condex_e = flag_v;
      4'b0111: condex_e = ~flag_v;
      4'b1000: condex_e = flag_c & ~flag_z;
      4'b1001: condex_e = ~flag_c | flag_z;
      4'b1010: condex_e = (flag_n == flag_v);
      4'b1011: condex_e = (flag_n != flag_v);
      4'b1100: condex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: condex_e = flag_z | (flag_n != flag_v);
      4'b1110: condex_e = 1'b1;
      default: condex_e = 1'b0;
    endcase
  end

  assign BranchTakenE = branch_e & condex_e;
  assign ldrstall     = memtoreg_e & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcwr_pending = PCSrcD | pcsrc_e | pcsrc_m;

  assign StallD = ldrstall;
  assign StallF = ldrstall | pcwr_pending;
  assign FlushD = pcwr_pending | PCSrcW | BranchTakenE;
  assign FlushE = ldrstall | BranchTakenE;

  // M-stage result is newer than W, so it wins when both match
  always_comb begin
    ForwardAE = 2'b00;
    if (Match[0] & regwrite_m)      ForwardAE = 2'b10;
    else if (Match[1] & RegWriteW)  ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (Match[2] & regwrite_m)      ForwardBE = 2'b10;
    else if (Match[3] & RegWriteW)  ForwardBE = 2'b01;
  end

  // D->E: a flushed slot becomes an all-zero bubble; its EQ cond is harmless
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      regwrite_e  <= 1'b0;
      memtoreg_e  <= 1'b0;
      memwrite_e  <= 1'b0;
      branch_e    <= 1'b0;
      pcsrc_e     <= 1'b0;
      flagwrite_e <= 2'b00;
      cond_e      <= 4'b0000;
    end else begin
      regwrite_e  <= RegWriteD;
      memtoreg_e  <= MemtoRegD;
      memwrite_e  <= MemWriteD;
      branch_e    <= BranchD;
      pcsrc_e     <= PCSrcD;
      flagwrite_e <= FlagWriteD;
      cond_e      <= CondD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      MemWriteM  <= 1'b0;
      pcsrc_m    <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      PCSrcW     <= 1'b0;
    end else begin
      regwrite_m <= regwrite_e & condex_e;
      memtoreg_m <= memtoreg_e;
      MemWriteM  <= memwrite_e & condex_e;
      pcsrc_m    <= pcsrc_e & condex_e;
      RegWriteW  <= regwrite_m;
      MemtoRegW  <= memtoreg_m;
      PCSrcW     <= pcsrc_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      FlagsQ <= 4'b0000;
    end else if (condex_e) begin
      if (flagwrite_e[1]) FlagsQ[3:2] <= ALUFlagsE[3:2];
      if (flagwrite_e[0]) FlagsQ[1:0] <= ALUFlagsE[1:0];
    end
  end

endmodule

// File: tb/tb_arm_pipe_hazard_ctrl.sv
// Bench for arm_pipe_hazard_ctrl: instruction-level pipeline model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_arm_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       RegWriteD, MemtoRegD, MemWriteD, BranchD, PCSrcD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD, ALUFlagsE, RA1D, RA2D, WA3E, Match;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, BranchTakenE, MemWriteM;
  logic       RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0] FlagsQ;

  arm_pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .ALUFlagsE(ALUFlagsE), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .Match(Match),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .FlagsQ(FlagsQ)
  );

  // One in-flight instruction's control bits; pipe[0]=E, pipe[1]=M, pipe[2]=W
  typedef struct packed {
    logic       rw, m2r, mw, br, pcs;
    logic [1:0] fw;
    logic [3:0] cond;
  } ctl_t;

  ctl_t       pipe [3];
  logic [3:0] mflags;
  int         tests = 0;
  int         fails = 0;

  function automatic bit holds(input logic [3:0] cond, input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit c = f[1];
    bit v = f[0];
    bit base;
    if (cond[3:1] == 3'd7) return (cond[0] == 1'b0);
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input bit hit_m, input bit hit_w);
    if (hit_m && pipe[1].rw) return 2'b10;
    if (hit_w && pipe[2].rw) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compare_all();
    bit ce   = holds(pipe[0].cond, mflags);
    bit bt   = pipe[0].br && ce;
    bit ldr  = pipe[0].m2r && (RA1D == WA3E || RA2D == WA3E);
    bit pend = PCSrcD || pipe[0].pcs || pipe[1].pcs;
    chk("model_ForwardAE", ForwardAE, fwd_sel(Match[0], Match[1]));
    chk("model_ForwardBE", ForwardBE, fwd_sel(Match[2], Match[3]));
    chk("model_StallF", StallF, ldr || pend);
    chk("model_StallD", StallD, ldr);
    chk("model_FlushD", FlushD, pend || pipe[2].pcs || bt);
    chk("model_FlushE", FlushE, ldr || bt);
    chk("model_BranchTakenE", BranchTakenE, bt);
    chk("model_MemWriteM", MemWriteM, pipe[1].mw);
    chk("model_RegWriteW", RegWriteW, pipe[2].rw);
    chk("model_MemtoRegW", MemtoRegW, pipe[2].m2r);
    chk("model_PCSrcW", PCSrcW, pipe[2].pcs);
    chk("model_FlagsQ", FlagsQ, mflags);
  endtask

  task automatic model_update();
    bit ce  = holds(pipe[0].cond, mflags);
    bit bt  = pipe[0].br && ce;
    bit ldr = pipe[0].m2r && (RA1D == WA3E || RA2D == WA3E);
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      mflags = 4'b0000;
    end else begin
      if (ce && pipe[0].fw[1]) mflags[3:2] = ALUFlagsE[3:2];
      if (ce && pipe[0].fw[0]) mflags[1:0] = ALUFlagsE[1:0];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[1].rw  = pipe[0].rw && ce;
      pipe[1].mw  = pipe[0].mw && ce;
      pipe[1].pcs = pipe[0].pcs && ce;
      if (ldr || bt) pipe[0] = '0;
      else pipe[0] = {RegWriteD, MemtoRegD, MemWriteD, BranchD, PCSrcD, FlagWriteD, CondD};
    end
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_d(input bit rw, input bit m2r, input bit mw, input bit br,
                       input bit pcs, input logic [1:0] fw, input logic [3:0] cond);
    RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; BranchD = br;
    PCSrcD = pcs; FlagWriteD = fw; CondD = cond;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 2'b00, 4'hE);
  endtask

  task automatic quiet_side();
    ALUFlagsE = 4'h0; RA1D = 4'h0; RA2D = 4'h0; WA3E = 4'h0; Match = 4'h0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ForwardAE"}, ForwardAE, 2'b00);
    chk({tag, "_ForwardBE"}, ForwardBE, 2'b00);
    chk({tag, "_StallF"}, StallF, 1'b0);
    chk({tag, "_StallD"}, StallD, 1'b0);
    chk({tag, "_FlushD"}, FlushD, 1'b0);
    chk({tag, "_FlushE"}, FlushE, 1'b0);
    chk({tag, "_BranchTakenE"}, BranchTakenE, 1'b0);
    chk({tag, "_MemWriteM"}, MemWriteM, 1'b0);
    chk({tag, "_RegWriteW"}, RegWriteW, 1'b0);
    chk({tag, "_MemtoRegW"}, MemtoRegW, 1'b0);
    chk({tag, "_PCSrcW"}, PCSrcW, 1'b0);
    chk({tag, "_FlagsQ"}, FlagsQ, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    nop();
    quiet_side();
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 1'b0;
    settle();
    check_cleared("reset_init");
    advance();

    // Forwarding: ADD R1 then SUB R2,R1,R3
    set_d(1, 0, 0, 0, 0, 2'b00, 4'hE); settle(); advance();
    set_d(1, 0, 0, 0, 0, 2'b00, 4'hE); settle(); advance();
    nop();
    Match = 4'b0001; settle(); chk("fwd_m", ForwardAE, 2'b10);
    Match = 4'b0011; settle(); chk("fwd_m_over_w", ForwardAE, 2'b10);
    Match = 4'b0100; settle(); chk("fwdB_m", ForwardBE, 2'b10);
    advance();
    Match = 4'b0010; settle(); chk("fwd_w", ForwardAE, 2'b01);
    Match = 4'b0000;
    advance();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end

    // Load-use: LDR R4 then ADD R5,R4,R6
    set_d(1, 1, 0, 0, 0, 2'b00, 4'hE); settle(); advance();
    set_d(1, 0, 0, 0, 0, 2'b00, 4'hE);
    RA1D = 4'd4; RA2D = 4'd6; WA3E = 4'd4;
    settle();
    chk("ldr_StallF", StallF, 1'b1);
    chk("ldr_StallD", StallD, 1'b1);
    chk("ldr_FlushE", FlushE, 1'b1);
    advance();
    WA3E = 4'd0;
    settle();
    chk("ldr_once_StallD", StallD, 1'b0);
    chk("ldr_once_FlushE", FlushE, 1'b0);
    advance();
    nop(); RA1D = 4'd0; RA2D = 4'd0; Match = 4'b0010;
    settle(); chk("ldr_fwd_w", ForwardAE, 2'b01);
    Match = 4'b0000;
    advance();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end

    // CMP sets Z, then BEQ taken / BNE not taken
    set_d(0, 0, 0, 0, 0, 2'b11, 4'hE); settle(); advance();
    ALUFlagsE = 4'b0100;
    set_d(0, 0, 0, 1, 0, 2'b00, 4'b0000); settle(); advance();
    ALUFlagsE = 4'b0000; nop();
    settle();
    chk("cmp_FlagsQ", FlagsQ, 4'b0100);
    chk("beq_taken", BranchTakenE, 1'b1);
    chk("beq_FlushD", FlushD, 1'b1);
    chk("beq_FlushE", FlushE, 1'b1);
    advance();
    settle();
    chk("beq_once_taken", BranchTakenE, 1'b0);
    chk("beq_once_FlushD", FlushD, 1'b0);
    advance();
    set_d(0, 0, 0, 1, 0, 2'b00, 4'b0001); settle(); advance();
    nop();
    settle();
    chk("bne_taken", BranchTakenE, 1'b0);
    chk("bne_FlushD", FlushD, 1'b0);
    chk("bne_FlushE", FlushE, 1'b0);
    advance();

    // CMP clearing all flags
    set_d(0, 0, 0, 0, 0, 2'b11, 4'hE); settle(); advance();
    nop(); settle(); advance();
    settle(); chk("clr_FlagsQ", FlagsQ, 4'b0000);
    advance();

    // ADDEQ with Z=0 (also marked as store and flag-setting): fully suppressed
    set_d(1, 0, 1, 0, 0, 2'b11, 4'b0000); settle(); advance();
    ALUFlagsE = 4'b1111; nop(); settle(); advance();
    ALUFlagsE = 4'b0000;
    settle();
    chk("addeq_MemWriteM", MemWriteM, 1'b0);
    chk("addeq_FlagsQ", FlagsQ, 4'b0000);
    advance();
    settle(); chk("addeq_RegWriteW", RegWriteW, 1'b0);
    advance();

    // MOV PC: fetch held while the write is in D/E/M, D flushed until it retires in W
    set_d(1, 0, 0, 0, 1, 2'b00, 4'hE);
    settle();
    chk("movpc_c1_StallF", StallF, 1'b1);
    chk("movpc_c1_FlushD", FlushD, 1'b1);
    advance();
    nop();
    for (int i = 2; i <= 3; i++) begin
      settle();
      chk("movpc_mid_StallF", StallF, 1'b1);
      chk("movpc_mid_FlushD", FlushD, 1'b1);
      advance();
    end
    settle();
    chk("movpc_c4_PCSrcW", PCSrcW, 1'b1);
    chk("movpc_c4_FlushD", FlushD, 1'b1);
    chk("movpc_c4_StallF", StallF, 1'b0);
    advance();
    settle();
    chk("movpc_c5_StallF", StallF, 1'b0);
    chk("movpc_c5_FlushD", FlushD, 1'b0);
    chk("movpc_c5_PCSrcW", PCSrcW, 1'b0);
    advance();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      RegWriteD  = 1'($urandom);
      MemtoRegD  = 1'($urandom);
      MemWriteD  = 1'($urandom);
      BranchD    = 1'($urandom);
      PCSrcD     = ($urandom_range(0, 7) == 0);
      FlagWriteD = 2'($urandom);
      CondD      = 4'($urandom);
      ALUFlagsE  = 4'($urandom);
      RA1D       = 4'($urandom_range(0, 3));
      RA2D       = 4'($urandom_range(0, 3));
      WA3E       = 4'($urandom_range(0, 3));
      Match      = 4'($urandom);
      settle();
      advance();
    end

    // Reset held two cycles during live traffic, including an R15 write in flight
    set_d(1, 0, 0, 0, 1, 2'b00, 4'hE); settle(); advance();
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1;
      set_d(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 4'($urandom));
      ALUFlagsE = 4'($urandom);
      Match = 4'($urandom);
      settle();
      advance();
    end
    reset = 1'b0;
    nop();
    quiet_side();
    Match = 4'b1111;
    settle();
    check_cleared("reset_traffic");
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
